// File: rtl/acl_guarded_regfile.sv
// Register file whose data registers are each guarded by a per-register allow-mask of user IDs.
// A single-entry response buffer returns read data or a denial; denials are counted and raise a sticky alert.
module acl_guarded_regfile #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned NUM_REGS  = 4,
    parameter int unsigned UID_W     = 3,
    parameter int unsigned ADMIN_UID = 4,
    parameter int unsigned ALLOW_RST = 8'h10,
    parameter int unsigned CNT_W     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic                        req_write,
    input  logic                        req_policy,
    input  logic                        req_lock,
    input  logic [$clog2(NUM_REGS)-1:0] req_addr,
    input  logic [UID_W-1:0]            req_uid,
    input  logic [DATA_W-1:0]           req_wdata,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_W-1:0]           rsp_rdata,
    output logic                        rsp_err,
    output logic [CNT_W-1:0]            viol_cnt,
    output logic                        alert
);

    localparam int unsigned AW = $clog2(NUM_REGS);
    localparam int unsigned MW = 1 << UID_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_t;

    state_t             state_r;
    logic [DATA_W-1:0]  data_r [NUM_REGS];
    logic [MW-1:0]      mask_r [NUM_REGS];
    logic               lock_r;
    logic [DATA_W-1:0]  rdata_r;
    logic               err_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               alert_r;

    logic               accept_s;
    logic               ready_s;
    logic               addr_ok_s;
    logic               allowed_s;
    logic               wr_data_s;
    logic               wr_mask_s;
    logic [MW-1:0]      mask_sel_s;
    logic [DATA_W-1:0]  data_sel_s;
    logic [DATA_W-1:0]  rdata_next_s;

    // Indices beyond NUM_REGS can only exist when NUM_REGS is not a power of two.
    generate
        if ((1 << AW) == NUM_REGS) begin : g_pow2
            assign addr_ok_s = 1'b1;
        end else begin : g_npow2
            assign addr_ok_s = ({1'b0, req_addr} < (AW+1)'(NUM_REGS));
        end
    endgenerate

    assign ready_s   = (state_r != ST_RESP) | rsp_ready;
    assign accept_s  = req_valid & ready_s;
    assign wr_data_s = accept_s & allowed_s & req_write & ~req_policy;
    assign wr_mask_s = accept_s & allowed_s & req_write & req_policy;

    assign req_ready = ready_s;
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_rdata = rdata_r;
    assign rsp_err   = err_r;
    assign viol_cnt  = cnt_r;
    assign alert     = alert_r;

    // Authorisation and response data, evaluated against state before this edge's update.
    always_comb begin
        mask_sel_s   = '0;
        data_sel_s   = '0;
        allowed_s    = 1'b0;
        rdata_next_s = '0;
        if (addr_ok_s) begin
            mask_sel_s = mask_r[req_addr];
            data_sel_s = data_r[req_addr];
        end else begin
            mask_sel_s = '0;
            data_sel_s = '0;
        end
        if (!addr_ok_s) begin
            allowed_s = 1'b0;
        end else if (req_policy) begin
            if (req_write) begin
                allowed_s = (req_uid == UID_W'(ADMIN_UID)) && !lock_r;
            end else begin
                allowed_s = 1'b1;
            end
        end else begin
            allowed_s = mask_sel_s[req_uid];
        end
        if (!allowed_s || req_write) begin
            rdata_next_s = '0;
        end else if (req_policy) begin
            rdata_next_s = DATA_W'(mask_sel_s);
        end else begin
            rdata_next_s = data_sel_s;
        end
    end

    // Response buffer FSM: capture on accept, hold until consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            rdata_r <= '0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_RESP;
                        rdata_r <= rdata_next_s;
                        err_r   <= !allowed_s;
                    end
                end
                ST_RESP: begin
                    if (accept_s) begin
                        state_r <= ST_RESP;
                        rdata_r <= rdata_next_s;
                        err_r   <= !allowed_s;
                    end else if (rsp_ready) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    // Protected storage: data registers, allow-masks and the one-way policy lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                data_r[i] <= '0;
                mask_r[i] <= MW'(ALLOW_RST);
            end
            lock_r <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (wr_data_s && (req_addr == AW'(i))) begin
                    data_r[i] <= req_wdata;
                end
                if (wr_mask_s && (req_addr == AW'(i))) begin
                    mask_r[i] <= req_wdata[MW-1:0];
                end
            end
            if (wr_mask_s && req_lock) begin
                lock_r <= 1'b1;
            end
        end
    end

    // Denial bookkeeping: saturating counter and sticky alert.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r   <= '0;
            alert_r <= 1'b0;
        end else if (accept_s && !allowed_s) begin
            alert_r <= 1'b1;
            if (cnt_r != {CNT_W{1'b1}}) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
        end
    end

endmodule
